// File: rtl/wb_soc_master_if.sv
// -----------------------------------------------------------------------------
// wb_soc_master_if
// Wishbone classic bus bundle between the wb_soc_master initiator and a slave.
//   p_wb_ADR_O  [31:0]  address           (master -> slave)
//   p_wb_DAT_O  [31:0]  write data        (master -> slave)
//   p_wb_SEL_O  [3:0]   byte selects      (master -> slave)
//   p_wb_WE_O           write enable      (master -> slave)
//   p_wb_CYC_O          cycle             (master -> slave)
//   p_wb_STB_O          strobe            (master -> slave)
//   p_wb_LOCK_O         bus lock, tied 0  (master -> slave)
//   p_wb_DAT_I  [31:0]  read data         (slave -> master)
//   p_wb_ACK_I          normal termination(slave -> master)
//   p_wb_ERR_I          error termination (slave -> master)
//   p_wb_RTY_I          retry termination (slave -> master)
// -----------------------------------------------------------------------------
interface wb_soc_master_if;
    logic [31:0] p_wb_ADR_O;
    logic [31:0] p_wb_DAT_O;
    logic [3:0]  p_wb_SEL_O;
    logic        p_wb_WE_O;
    logic        p_wb_CYC_O;
    logic        p_wb_STB_O;
    logic        p_wb_LOCK_O;
    logic [31:0] p_wb_DAT_I;
    logic        p_wb_ACK_I;
    logic        p_wb_ERR_I;
    logic        p_wb_RTY_I;

    modport master (
        output p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O,
               p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
        input  p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
    );

    modport slave (
        input  p_wb_ADR_O, p_wb_DAT_O, p_wb_SEL_O, p_wb_WE_O,
               p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O,
        output p_wb_DAT_I, p_wb_ACK_I, p_wb_ERR_I, p_wb_RTY_I
    );
endinterface

// File: rtl/wb_soc_master.sv
// -----------------------------------------------------------------------------
// wb_soc_master
// Wishbone classic single-transfer bus master. Takes one read/write command at
// a time on a valid/ready port, runs the bus cycle until ACK/ERR/RTY (or a
// timeout), and returns a one-cycle response pulse with read data and status.
//
// Ports:
//   p_clk, p_resetn      clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake (accepted when both high)
//   cmd_we/addr/data/sel command fields, latched on acceptance
//   rsp_valid            one-cycle response pulse, no backpressure
//   rsp_data/rsp_status  read data / status (00 OK, 01 ERR, 10 TIMEOUT,
//                        11 RETRY_FAIL); held until the next response
//   busy                 high whenever not idle
//   wb                   Wishbone bus (master modport)
//   irq, irq_clr         sticky error interrupt, only with WB_MASTER_IRQ_EN
//
// Optional feature macro: WB_MASTER_IRQ_EN
// -----------------------------------------------------------------------------
module wb_soc_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic           p_clk,
    input  logic           p_resetn,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_we,
    input  logic [31:0]    cmd_addr,
    input  logic [31:0]    cmd_data,
    input  logic [3:0]     cmd_sel,
    output logic           rsp_valid,
    output logic [31:0]    rsp_data,
    output logic [1:0]     rsp_status,
    output logic           busy,
`ifdef WB_MASTER_IRQ_EN
    output logic           irq,
    input  logic           irq_clr,
`endif
    wb_soc_master_if.master wb
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_BACKOFF = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ERR   = 2'b01;
    localparam logic [1:0] ST_TMO   = 2'b10;
    localparam logic [1:0] ST_RFAIL = 2'b11;

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]    state_q, state_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    sel_q, sel_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic [1:0]    rsp_status_q, rsp_status_d;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        data_d       = data_q;
        sel_d        = sel_q;
        tmo_d        = tmo_q;
        retry_d      = retry_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    we_d    = cmd_we;
                    addr_d  = cmd_addr;
                    data_d  = cmd_data;
                    sel_d   = cmd_sel;
                    tmo_d   = '0;
                    retry_d = '0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                // Termination priority ERR > ACK > RTY, then timeout.
                if (wb.p_wb_ERR_I) begin
                    rsp_status_d = ST_ERR;
                    rsp_data_d   = '0;
                    state_d      = S_RESP;
                end else if (wb.p_wb_ACK_I) begin
                    rsp_status_d = ST_OK;
                    rsp_data_d   = we_q ? '0 : wb.p_wb_DAT_I;
                    state_d      = S_RESP;
                end else if (wb.p_wb_RTY_I) begin
                    if ((32'(retry_q) + 32'd1) < MAX_RETRY) begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_BACKOFF;
                    end else begin
                        rsp_status_d = ST_RFAIL;
                        rsp_data_d   = '0;
                        state_d      = S_RESP;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    rsp_status_d = ST_TMO;
                    rsp_data_d   = '0;
                    state_d      = S_RESP;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_BACKOFF: begin
                tmo_d   = '0;
                state_d = S_REQ;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            sel_q        <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            rsp_data_q   <= '0;
            rsp_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            sel_q        <= sel_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign cmd_ready      = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_data       = rsp_data_q;
    assign rsp_status     = rsp_status_q;

    assign wb.p_wb_CYC_O  = (state_q == S_REQ);
    assign wb.p_wb_STB_O  = (state_q == S_REQ);
    assign wb.p_wb_ADR_O  = addr_q;
    assign wb.p_wb_DAT_O  = data_q;
    assign wb.p_wb_SEL_O  = sel_q;
    assign wb.p_wb_WE_O   = we_q;
    assign wb.p_wb_LOCK_O = 1'b0;

`ifdef WB_MASTER_IRQ_EN
    logic irq_q, irq_d;

    // Set while the failing response is on the port, so it wins over a clear
    // issued in that same cycle.
    always_comb begin
        irq_d = irq_q;
        if (irq_clr) irq_d = 1'b0;
        if (state_q == S_RESP && rsp_status_q != ST_OK) irq_d = 1'b1;
    end

    always_ff @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn) irq_q <= 1'b0;
        else           irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_wb_soc_master.sv
// -----------------------------------------------------------------------------
// tb_wb_soc_master
// Self-checking bench for wb_soc_master: a table of directed commands against
// a configurable slave model, plus hand-written reset-abort and irq sequences.
// -----------------------------------------------------------------------------
module tb_wb_soc_master;

    localparam int M_NONE = 0;
    localparam int M_ACK  = 1;
    localparam int M_ERR  = 2;
    localparam int M_RTY  = 3;
    localparam int M_EA   = 4;   // ERR and ACK together

    logic        p_clk = 1'b0;
    logic        p_resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_status;
    logic        busy;
`ifdef WB_MASTER_IRQ_EN
    logic        irq;
    logic        irq_clr = 1'b0;
`endif

    always #5 p_clk = ~p_clk;

    wb_soc_master_if wb ();

    wb_soc_master #(.TIMEOUT_CYCLES(16), .MAX_RETRY(3)) dut (
        .p_clk      (p_clk),
        .p_resetn   (p_resetn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_addr   (cmd_addr),
        .cmd_data   (cmd_data),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .busy       (busy),
`ifdef WB_MASTER_IRQ_EN
        .irq        (irq),
        .irq_clr    (irq_clr),
`endif
        .wb         (wb)
    );

    // Slave model: terminates once STB has been high for sl_wait cycles.
    int          sl_mode = M_NONE;
    int unsigned sl_wait = 0;
    logic [31:0] sl_rdata = '0;
    int unsigned stb_cyc;

    always @(posedge p_clk or negedge p_resetn) begin
        if (!p_resetn)           stb_cyc <= 0;
        else if (wb.p_wb_STB_O)  stb_cyc <= stb_cyc + 1;
        else                     stb_cyc <= 0;
    end

    assign wb.p_wb_DAT_I = sl_rdata;
    assign wb.p_wb_ACK_I = wb.p_wb_STB_O && (stb_cyc >= sl_wait) &&
                           (sl_mode == M_ACK || sl_mode == M_EA);
    assign wb.p_wb_ERR_I = wb.p_wb_STB_O && (stb_cyc >= sl_wait) &&
                           (sl_mode == M_ERR || sl_mode == M_EA);
    assign wb.p_wb_RTY_I = wb.p_wb_STB_O && (stb_cyc >= sl_wait) &&
                           (sl_mode == M_RTY);

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Observations of the last transaction
    logic [1:0]  r_status;
    logic [31:0] r_data;
    int          r_stb, r_ph, r_lat;
    logic        r_busok, r_cyc_rsp;

    // Issue one command, keep cmd_valid high with different fields while busy
    // (must be ignored), and watch the bus until rsp_valid. r_lat counts cycles
    // after the accepting edge.
    task automatic run_cmd(input logic we, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] sel);
        int   k;
        logic prev;
        @(negedge p_clk);
        k = 0;
        while (!cmd_ready && k < 50) begin
            @(negedge p_clk);
            k++;
        end
        check("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_data  = data;
        cmd_sel   = sel;
        @(posedge p_clk);
        #1;
        cmd_we    = ~we;
        cmd_addr  = ~addr;
        cmd_data  = ~data;
        cmd_sel   = ~sel;
        r_stb = 0; r_ph = 0; r_lat = 0; r_busok = 1'b1; r_cyc_rsp = 1'b1;
        r_status = 2'bxx; r_data = 'x;
        prev = 1'b0;
        for (k = 1; k <= 200; k++) begin
            @(negedge p_clk);
            if (wb.p_wb_STB_O) begin
                r_stb++;
                if (!prev) r_ph++;
                if (wb.p_wb_ADR_O !== addr || wb.p_wb_DAT_O !== data ||
                    wb.p_wb_SEL_O !== sel  || wb.p_wb_WE_O !== we ||
                    wb.p_wb_CYC_O !== 1'b1 || wb.p_wb_LOCK_O !== 1'b0)
                    r_busok = 1'b0;
            end
            prev = wb.p_wb_STB_O;
            if (rsp_valid) begin
                r_lat     = k;
                r_status  = rsp_status;
                r_data    = rsp_data;
                r_cyc_rsp = wb.p_wb_CYC_O | wb.p_wb_STB_O;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          mode;
        int unsigned wt;
        logic [31:0] rdata;
        logic [1:0]  est;
        logic [31:0] edata;
        int          estb;
        int          eph;
        int          elat;
    } vec_t;

    vec_t vecs [8];

    initial begin
        //           we    addr          data          sel   mode    wt rdata         st     edata         stb ph lat
        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, M_ACK,  0, 32'h0,         2'b00, 32'h0,         1,  1, 2};
        vecs[1] = '{1'b0, 32'h0000_0020, 32'h0,         4'hF, M_ACK,  3, 32'h1234_5678, 2'b00, 32'h1234_5678, 4,  1, 5};
        vecs[2] = '{1'b0, 32'h0000_0024, 32'h0,         4'h3, M_RTY,  0, 32'hCAFE_F00D, 2'b11, 32'h0,         3,  3, 6};
        vecs[3] = '{1'b0, 32'h0000_0028, 32'h0,         4'hF, M_EA,   0, 32'h1111_1111, 2'b01, 32'h0,         1,  1, 2};
        vecs[4] = '{1'b0, 32'h0000_002C, 32'h0,         4'hF, M_NONE, 0, 32'h5555_5555, 2'b10, 32'h0,         16, 1, 17};
        vecs[5] = '{1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'h5, M_ERR,  2, 32'h0,         2'b01, 32'h0,         3,  1, 4};
        vecs[6] = '{1'b0, 32'h0000_0044, 32'h0,         4'hC, M_ACK,  1, 32'h89AB_CDEF, 2'b00, 32'h89AB_CDEF, 2,  1, 3};
        vecs[7] = '{1'b1, 32'h0000_0048, 32'h0102_0304, 4'h1, M_RTY,  0, 32'h0,         2'b11, 32'h0,         3,  3, 6};

        // Reset state
        repeat (2) @(negedge p_clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp", {rsp_status, rsp_data}, 0);
        check("rst_bus", {wb.p_wb_CYC_O, wb.p_wb_STB_O, wb.p_wb_WE_O,
                          wb.p_wb_LOCK_O, wb.p_wb_SEL_O}, 0);
        check("rst_adr", wb.p_wb_ADR_O, 0);
`ifdef WB_MASTER_IRQ_EN
        check("rst_irq", irq, 0);
`endif
        p_resetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            sl_mode  = vecs[i].mode;
            sl_wait  = vecs[i].wt;
            sl_rdata = vecs[i].rdata;
            run_cmd(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel);
            check($sformatf("v%0d_status", i), r_status, vecs[i].est);
            check($sformatf("v%0d_data", i), r_data, vecs[i].edata);
            check($sformatf("v%0d_stb_cycles", i), r_stb, vecs[i].estb);
            check($sformatf("v%0d_stb_phases", i), r_ph, vecs[i].eph);
            check($sformatf("v%0d_latency", i), r_lat, vecs[i].elat);
            check($sformatf("v%0d_bus_fields", i), r_busok, 1);
            check($sformatf("v%0d_cyc_in_resp", i), r_cyc_rsp, 0);
            @(posedge p_clk);
            #1;
            check($sformatf("v%0d_ready_after", i), cmd_ready, 1);
            check($sformatf("v%0d_rsp_pulse_end", i), rsp_valid, 0);
            check($sformatf("v%0d_hold", i), {30'd0, rsp_status}, {30'd0, vecs[i].est});
            check($sformatf("v%0d_hold_data", i), rsp_data, vecs[i].edata);
        end

        // Reset during the 2nd wait cycle of a read
        begin
            logic saw_rsp;
            sl_mode  = M_ACK;
            sl_wait  = 10;
            sl_rdata = 32'h7777_7777;
            @(negedge p_clk);
            cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h30; cmd_sel = 4'hF;
            @(posedge p_clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge p_clk);
            @(negedge p_clk);
            check("abort_stb_before", wb.p_wb_STB_O, 1);
            #2;
            p_resetn = 1'b0;
            #1;
            check("abort_cyc_stb_drop", {wb.p_wb_CYC_O, wb.p_wb_STB_O}, 0);
            check("abort_ready", cmd_ready, 1);
            saw_rsp = 1'b0;
            repeat (3) begin
                @(negedge p_clk);
                if (rsp_valid) saw_rsp = 1'b1;
            end
            p_resetn = 1'b1;
            sl_wait  = 0;
            repeat (4) begin
                @(negedge p_clk);
                if (rsp_valid) saw_rsp = 1'b1;
            end
            check("abort_no_rsp", saw_rsp, 0);
            check("abort_ready_after", cmd_ready, 1);
            run_cmd(1'b1, 32'h50, 32'h0BAD_F00D, 4'hF);
            check("post_abort_status", r_status, 2'b00);
            check("post_abort_latency", r_lat, 2);
            check("post_abort_bus", r_busok, 1);
        end

`ifdef WB_MASTER_IRQ_EN
        @(negedge p_clk);
        irq_clr = 1'b1;
        @(posedge p_clk);
        #1;
        irq_clr = 1'b0;
        check("irq_cleared", irq, 0);
        sl_mode = M_ERR; sl_wait = 0;
        run_cmd(1'b0, 32'h60, 32'h0, 4'hF);
        check("irq_err_status", r_status, 2'b01);
        @(posedge p_clk);
        #1;
        check("irq_set_on_err", irq, 1);
        repeat (3) @(negedge p_clk);
        check("irq_sticky", irq, 1);
        irq_clr = 1'b1;
        @(posedge p_clk);
        #1;
        irq_clr = 1'b0;
        check("irq_clr_pulse", irq, 0);
        sl_mode = M_NONE;
        irq_clr = 1'b1;
        run_cmd(1'b0, 32'h64, 32'h0, 4'hF);
        check("irq_tmo_status", r_status, 2'b10);
        @(posedge p_clk);
        #1;
        irq_clr = 1'b0;
        check("irq_set_wins", irq, 1);
        @(posedge p_clk);
        #1;
        check("irq_stays", irq, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
